hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline sequencing controller for the 5-stage core. Detects load-use hazards on ID-stage
//   operands (the instruction whose immediate/regs are being decoded), inserts ID/EX bubbles,
//   flushes on taken branches resolved in MEM, and runs a halt/drain handshake for debug or
//   multicycle units. Also keeps saturating stall and flush event counters.
// PARAMETERS
//   REG_W        5   register-index width
//   CNT_W        32  width of stall_count / flush_count
//   DRAIN_CYCLES 4   cycles spent draining before halt_ack asserts (>=1)
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      synchronous reset, active low
//   id_valid     in   1      IF/ID register holds a real instruction
//   id_rs1       in   REG_W  ID rs1 index
//   id_rs2       in   REG_W  ID rs2 index
//   id_use_rs1   in   1      ID instruction reads rs1
//   id_use_rs2   in   1      ID instruction reads rs2 (S/B/R types)
//   ex_valid     in   1      ID/EX holds a real instruction
//   ex_mem_read  in   1      EX instruction is a load
//   ex_rd        in   REG_W  EX destination index
//   branch_taken in   1      taken branch/jump resolved in MEM this cycle
//   halt_req     in   1      level request to freeze the pipeline
//   pc_write     out  1      PC register enable
//   ifid_write   out  1      IF/ID register enable
//   ifid_flush   out  1      clear IF/ID valid
//   idex_bubble  out  1      load NOP (all controls 0, imm 0) into ID/EX
//   exmem_flush  out  1      clear EX/MEM valid
//   halt_ack     out  1      registered: pipeline frozen and drained
//   stall_count  out  CNT_W  load-use stalls taken (saturating)
//   flush_count  out  CNT_W  branch flushes taken (saturating)
// BEHAVIOUR
//   - States RUN=2'b00, STALL=2'b01, DRAIN=2'b10, HALTED=2'b11; state, counters, drain count and
//     halt_ack are registered; stage enables/flushes are combinational from state + inputs.
//   - Reset (rst_n=0 at edge): state RUN, counters 0, drain count 0, halt_ack 0. While rst_n=0:
//     pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=1.
//   - lu = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) &
//          ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//   - Default (no event): pc_write=ifid_write=1, flushes/bubble 0.
//   - Priority in every state: branch_taken > halt_req > lu.
//   - branch_taken (any state): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1,
//     exmem_flush=1; flush_count+1. Next: RUN from RUN/STALL; DRAIN stays DRAIN (count continues);
//     HALTED stays HALTED (redirect captured, nothing fetched beyond).
//   - RUN, halt_req: pc_write=0, ifid_write=0, idex_bubble=1; drain count<=DRAIN_CYCLES-1; ->DRAIN.
//   - RUN, lu: pc_write=0, ifid_write=0, idex_bubble=1; stall_count+1; ->STALL. Exactly one bubble.
//   - STALL: lu masked (stale EX info); enables 1; ->RUN, or ->DRAIN if halt_req.
//   - DRAIN: pc_write=0, ifid_write=0, idex_bubble=1; count decrements; at count 0 ->HALTED.
//     halt_req dropping during DRAIN: ->RUN next cycle, halt_ack never asserts.
//   - HALTED: halt_ack=1, pc_write=0, ifid_write=0, idex_bubble=1; halt_req=0 -> RUN;
//     halt_ack falls the same edge the state leaves HALTED.
//   - Counters saturate at all-ones, never wrap. Branch and lu in same cycle: flush only, no stall count.
//   - Reset mid-STALL/DRAIN/HALTED: returns to RUN, halt_ack 0 next cycle, counters cleared.
// TESTING
//   1 lw x5 in EX, ID add x6,x5,x1 (use_rs1) -> one cycle pc_write=0/idex_bubble=1, stall_count=1.
//   2 ex_rd=0 with load, id_rs1=0 -> no stall; ex_mem_read=0 with match -> no stall.
//   3 lu and branch_taken same cycle -> all flushes 1, pc_write=1, flush_count=1, stall_count=0.
//   4 halt_req at cycle 0 (DRAIN_CYCLES=4) -> halt_ack=1 at cycle 5; release -> RUN, ack 0 next edge.
//   5 stall_count preset near max (force CNT_W=4): 16 stalls -> holds 4'hF.
//   6 rst_n=0 during DRAIN -> squash outputs while low; after release RUN, counters 0, halt_ack 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stall detection,
// branch flush, halt/drain handshake and saturating stall/flush event counters.
module hazard_ctrl #(
   parameter int unsigned REG_W        = 5,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             branch_taken,
   input  logic             halt_req,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic             halt_ack,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
   localparam logic [DCNT_W-1:0] DrainInit = DCNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      StRun    = 2'b00,
      StStall  = 2'b01,
      StDrain  = 2'b10,
      StHalted = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [DCNT_W-1:0]   drain_q, drain_d;
   logic                halt_ack_q, halt_ack_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
   logic                stall_inc, flush_inc;
   logic                lu;
   logic                rs1_hit, rs2_hit;

   // Load-use hazard: ID reads a register that the load in EX has not yet produced.
   always_comb begin
      rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
      rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
      lu      = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);
   end

   // Next-state, drain counter and stage-control outputs; branch > halt > load-use.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;

      if (branch_taken) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
         flush_inc   = 1'b1;
         unique case (state_q)
            StRun, StStall: state_d = StRun;
            // Redirect is absorbed but the drain keeps counting down.
            StDrain: begin
               state_d = StDrain;
               if (drain_q != '0) drain_d = drain_q - 1'b1;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
         endcase
      end else begin
         unique case (state_q)
            StRun: begin
               if (halt_req) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  drain_d     = DrainInit;
                  state_d     = StDrain;
               end else if (lu) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  stall_inc   = 1'b1;
                  state_d     = StStall;
               end
            end
            // EX now holds the bubble we inserted, so its load info is stale: no re-stall.
            StStall: begin
               if (halt_req) begin
                  drain_d = DrainInit;
                  state_d = StDrain;
               end else begin
                  state_d = StRun;
               end
            end
            StDrain: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               if (!halt_req) begin
                  state_d = StRun;
               end else if (drain_q == '0) begin
                  state_d = StHalted;
               end else begin
                  drain_d = drain_q - 1'b1;
               end
            end
            StHalted: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               if (!halt_req) state_d = StRun;
            end
            default: state_d = StRun;
         endcase
      end

      // Squash the whole pipeline while reset is held.
      if (!rst_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end
   end

   // Saturating event counters and registered halt acknowledge.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
      halt_ack_d = (state_d == StHalted);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StRun;
         drain_q     <= '0;
         halt_ack_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         halt_ack_q  <= halt_ack_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign halt_ack    = halt_ack_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second 4-bit-counter instance
// shares the stimulus to exercise counter saturation.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_mem_read;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       branch_taken, halt_req;

   logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, halt_ack;
   logic [31:0] stall_count, flush_count;
   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush, s_halt_ack;
   logic [3:0]  s_stall_count, s_flush_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(5), .CNT_W(32), .DRAIN_CYCLES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .halt_req(halt_req), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
      .halt_ack(halt_ack), .stall_count(stall_count), .flush_count(flush_count)
   );

   hazard_ctrl #(.REG_W(5), .CNT_W(4), .DRAIN_CYCLES(4)) u_dut_small (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .halt_req(halt_req), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
      .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .exmem_flush(s_exmem_flush),
      .halt_ack(s_halt_ack), .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_valid = 0; ex_mem_read = 0;
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; branch_taken = 0; halt_req = 0;
   endtask

   // lw x5 in EX, ID add x6,x5,x1 reading rs1
   task automatic load_use_inputs();
      id_valid = 1; id_use_rs1 = 1; id_use_rs2 = 1; id_rs1 = 5; id_rs2 = 1;
      ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
   endtask

   task automatic check_squash(input string tag);
      check({tag, "_pc_write"},    32'(pc_write),    32'd0);
      check({tag, "_ifid_write"},  32'(ifid_write),  32'd0);
      check({tag, "_ifid_flush"},  32'(ifid_flush),  32'd1);
      check({tag, "_idex_bubble"}, 32'(idex_bubble), 32'd1);
      check({tag, "_exmem_flush"}, 32'(exmem_flush), 32'd1);
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      #1;
      check_squash("rst_hold");
      tick();
      tick();
      check("rst_halt_ack", 32'(halt_ack), 32'd0);
      check("rst_stall_cnt", stall_count, 32'd0);
      check("rst_flush_cnt", flush_count, 32'd0);
      rst_n = 1;
      #1;
      check("idle_pc_write", 32'(pc_write), 32'd1);
      check("idle_bubble", 32'(idex_bubble), 32'd0);

      // 1: single load-use stall
      load_use_inputs();
      #1;
      check("lu_pc_write", 32'(pc_write), 32'd0);
      check("lu_ifid_write", 32'(ifid_write), 32'd0);
      check("lu_bubble", 32'(idex_bubble), 32'd1);
      tick();
      check("lu_stall_cnt", stall_count, 32'd1);
      check("lu_masked_pc_write", 32'(pc_write), 32'd1);
      check("lu_masked_bubble", 32'(idex_bubble), 32'd0);
      tick();
      check("lu_once_stall_cnt", stall_count, 32'd1);
      idle_inputs();

      // rs2 path (S/B/R types)
      id_valid = 1; id_use_rs2 = 1; id_rs2 = 7; ex_valid = 1; ex_mem_read = 1; ex_rd = 7;
      #1;
      check("lu_rs2_bubble", 32'(idex_bubble), 32'd1);
      tick();
      idle_inputs();
      tick();
      check("lu_rs2_stall_cnt", stall_count, 32'd2);

      // 2: x0 destination and non-load producers never stall
      load_use_inputs();
      ex_rd = 0; id_rs1 = 0;
      #1;
      check("x0_pc_write", 32'(pc_write), 32'd1);
      ex_rd = 5; id_rs1 = 5; ex_mem_read = 0;
      #1;
      check("noload_pc_write", 32'(pc_write), 32'd1);
      ex_mem_read = 1; id_use_rs1 = 0;
      #1;
      check("nouse_pc_write", 32'(pc_write), 32'd1);
      tick();
      check("no_stall_cnt", stall_count, 32'd2);

      // 3: load-use and branch together -> flush only
      load_use_inputs();
      branch_taken = 1;
      #1;
      check("br_pc_write", 32'(pc_write), 32'd1);
      check("br_ifid_flush", 32'(ifid_flush), 32'd1);
      check("br_bubble", 32'(idex_bubble), 32'd1);
      check("br_exmem_flush", 32'(exmem_flush), 32'd1);
      tick();
      check("br_flush_cnt", flush_count, 32'd1);
      check("br_stall_cnt", stall_count, 32'd2);
      idle_inputs();
      #1;
      check("br_after_pc_write", 32'(pc_write), 32'd1);

      // 4: halt handshake, ack after DRAIN_CYCLES+1 edges
      halt_req = 1;
      #1;
      check("halt_req_pc_write", 32'(pc_write), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("halt_ack_c%0d", i), 32'(halt_ack), (i == 5) ? 32'd1 : 32'd0);
         check($sformatf("halt_pc_write_c%0d", i), 32'(pc_write), 32'd0);
      end
      // branch while halted: flush but stay frozen
      branch_taken = 1;
      tick();
      branch_taken = 0;
      check("halted_br_ack", 32'(halt_ack), 32'd1);
      check("halted_br_flush_cnt", flush_count, 32'd2);
      halt_req = 0;
      #1;
      check("halted_hold_pc_write", 32'(pc_write), 32'd0);
      tick();
      check("release_ack", 32'(halt_ack), 32'd0);
      check("release_pc_write", 32'(pc_write), 32'd1);

      // halt_req dropped mid-drain: back to RUN, never acked
      halt_req = 1;
      tick();
      tick();
      halt_req = 0;
      tick();
      check("abort_pc_write", 32'(pc_write), 32'd1);
      tick();
      tick();
      tick();
      check("abort_ack", 32'(halt_ack), 32'd0);

      // 5: 16 more stalls; 4-bit counter saturates
      for (int i = 0; i < 16; i++) begin
         load_use_inputs();
         tick();
         idle_inputs();
         tick();
      end
      check("sat_small_stall", 32'(s_stall_count), 32'hF);
      check("sat_main_stall", stall_count, 32'd18);
      check("sat_small_flush", 32'(s_flush_count), 32'd2);

      // 6: reset during DRAIN
      halt_req = 1;
      tick();
      tick();
      rst_n = 0;
      #1;
      check_squash("rst_drain");
      tick();
      check_squash("rst_drain_edge");
      rst_n = 1;
      halt_req = 0;
      #1;
      check("rst_rel_pc_write", 32'(pc_write), 32'd1);
      check("rst_rel_ack", 32'(halt_ack), 32'd0);
      check("rst_rel_stall_cnt", stall_count, 32'd0);
      check("rst_rel_flush_cnt", flush_count, 32'd0);
      check("rst_rel_small_stall", 32'(s_stall_count), 32'd0);

      // reset while HALTED drops the ack
      halt_req = 1;
      for (int i = 0; i < 5; i++) tick();
      check("rehalt_ack", 32'(halt_ack), 32'd1);
      rst_n = 0;
      tick();
      check("rst_halted_ack", 32'(halt_ack), 32'd0);
      rst_n = 1;
      halt_req = 0;
      tick();
      check("post_rst_pc_write", 32'(pc_write), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
